wr_fifo_pattern_gen: RTL and testbench
======================================

# wr_fifo_pattern_gen

Parametrised test-pattern source for the USB driver write-FIFO path. On a start command it emits a burst of words in one of four selectable patterns (alternating, incrementing, LFSR, constant), writing one word per cycle whenever the downstream FIFO is not full. It sits in front of the USB write FIFO in bring-up and loopback builds. It replaces the fixed 0xAA/0x55 source with configurable width, burst length, stop control and completion status.

## Interface
- DATA_W, 8, data word width (≥2)
- LEN_W, 16, width of burst length and word counter
- LFSR_POLY, 8'hB8, Galois LFSR feedback mask (DATA_W bits); default is maximal-length for DATA_W=8
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a burst; sampled only in IDLE
- stop  in  1  end the current burst early; sampled only in RUN
- mode  in  2  pattern select, latched at start: 0 alternating, 1 increment, 2 LFSR, 3 constant
- seed  in  DATA_W  first word of the burst, latched at start
- burst_len  in  LEN_W  words per burst, latched at start; 0 = continuous until stop
- full  in  1  downstream FIFO full
- valid  out  1  write enable to FIFO; a word is accepted in every cycle valid=1
- dout  out  DATA_W  write data
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at end of burst
- word_cnt  out  LEN_W  words accepted in current/last burst

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: valid=0. On start=1: latch mode/seed/burst_len, load pattern register with seed (with LFSR mode and seed=0, load 1), clear word_cnt, go to RUN.
- RUN: valid = ~full (combinational). On each accept (valid=1), pattern register advances and word_cnt increments.
- Pattern advance, from current word p:
  - mode 0: ~p (seed, ~seed, seed, ...)
  - mode 1: p+1, wraps modulo 2^DATA_W
  - mode 2: (p>>1) ^ (p[0] ? LFSR_POLY : 0)
  - mode 3: p (unchanged)
- Burst end: accept while word_cnt == burst_len-1 (burst_len≠0) -> DONE. word_cnt ends equal to burst_len.
- stop=1 in RUN -> DONE next cycle; a word accepted in that same cycle counts. stop and the last accept in the same cycle -> single transition to DONE.
- burst_len=0: run until stop; word_cnt wraps modulo 2^LEN_W with no effect on state.
- DONE: valid=0, done=1 for exactly one cycle, then IDLE. start is ignored in RUN and DONE.
- dout, word_cnt hold their last values in IDLE until the next start.
- full=1 stalls: pattern register and word_cnt hold; no word is lost or skipped.

## Timing
- Reset (rst=1 at clk edge): state IDLE, dout=0, valid=0, busy=0, done=0, word_cnt=0. Reset mid-burst aborts immediately, with no done pulse.
- Start latency: start in cycle N -> busy=1 and dout=seed in N+1; valid=1 in N+1 if full=0.
- Throughput: one word per cycle while full=0.
- valid has a combinational path from full. All other outputs are registered.
- Last accept in cycle M -> done=1, busy=0, valid=0 in M+1; IDLE in M+2. Earliest restart: start in M+2.

## Test plan
- mode 0, seed 0xAA, burst_len 4, full=0: dout AA,55,AA,55 on 4 consecutive valid cycles; done pulses the next cycle; word_cnt=4.
- mode 1, seed 0xFE, burst_len 4, full toggling 1/0 every cycle: accepted words are FE,FF,00,01 with no repeats or gaps; done follows the 4th accept.
- mode 2, seed 0x01, burst_len 4: accepted words 01,B8,5C,2E. A second run with seed 0x00 starts at 01.
- mode 3, seed 0x3C, burst_len 0: constant 3C continues; stop asserted after 10 accepts -> word_cnt=10, one done pulse, valid=0 thereafter.
- start asserted during RUN: ignored, latched values unchanged. rst asserted mid-burst: all outputs reach reset values next cycle, no done pulse.
- full held high for 20 cycles mid-burst: valid=0, dout and word_cnt frozen; the burst resumes from the same word when full drops.

Source files
------------

// File: rtl/wr_fifo_pattern_gen.sv
// wr_fifo_pattern_gen
//
// Test-pattern source for the USB write FIFO. A start command in IDLE latches
// a pattern mode, a seed word and a burst length. The block then writes one
// word per cycle for as long as the downstream FIFO is not full. The burst
// ends when the requested number of words has been accepted, or when stop is
// asserted. A burst length of zero runs until stop.
//
// Parameters:
//   DATA_W     data word width (>= 2)
//   LEN_W      width of burst length and word counter
//   LFSR_POLY  Galois LFSR feedback mask, DATA_W bits wide
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      begin a burst (sampled only in IDLE)
//   stop       end the current burst early (sampled only in RUN)
//   mode       pattern select: 0 alternating, 1 increment, 2 LFSR, 3 constant
//   seed       first word of the burst
//   burst_len  words per burst, 0 = continuous until stop
//   full       downstream FIFO full
//   valid      FIFO write enable; a word is accepted in every cycle it is high
//   dout       write data
//   busy       high while a burst is running
//   done       one-cycle pulse when a burst ends
//   word_cnt   words accepted in the current or last burst

module wr_fifo_pattern_gen #(
    parameter int                DATA_W    = 8,
    parameter int                LEN_W     = 16,
    parameter logic [DATA_W-1:0] LFSR_POLY = 8'hB8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              full,
    output logic              valid,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  word_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_ALT   = 2'd0;
    localparam logic [1:0] M_INC   = 2'd1;
    localparam logic [1:0] M_LFSR  = 2'd2;
    localparam logic [1:0] M_CONST = 2'd3;

    logic [1:0]        state;
    logic [1:0]        mode_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] next_pattern;
    logic [DATA_W-1:0] start_word;
    logic [LEN_W-1:0]  count;
    logic              accept;
    logic              last_word;

    // The write enable follows full combinationally so that a FIFO that frees
    // a slot can take a word in the very same cycle.
    assign accept = (state == S_RUN) && !full;
    assign valid  = accept;
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);
    assign dout   = pattern;
    assign word_cnt = count;

    // The final word of a fixed-length burst is the one accepted while the
    // counter still reads burst_len-1. A zero length never matches, so the
    // counter may wrap freely in continuous mode.
    assign last_word = accept && (len_q != '0) && (count == len_q - LEN_W'(1));

    // The next word is derived from the current one, so a stalled cycle simply
    // holds the register and no word is lost or skipped.
    always_comb begin
        next_pattern = pattern;
        case (mode_q)
            M_ALT:   next_pattern = ~pattern;
            M_INC:   next_pattern = pattern + DATA_W'(1);
            M_LFSR:  next_pattern = (pattern >> 1) ^ (pattern[0] ? LFSR_POLY : '0);
            M_CONST: next_pattern = pattern;
            default: next_pattern = pattern;
        endcase
    end

    // An all-zero LFSR state would lock up, so a zero seed in LFSR mode is
    // replaced by 1.
    always_comb begin
        start_word = seed;
        if ((mode == M_LFSR) && (seed == '0)) begin
            start_word = DATA_W'(1);
        end
    end

    // The main state machine. Pattern and counter advance only on accepted
    // words. In RUN, stop and the final accept in the same cycle produce a
    // single move to DONE. After DONE the block returns to IDLE, where dout and
    // word_cnt keep their values until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mode_q  <= M_ALT;
            len_q   <= '0;
            pattern <= '0;
            count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        len_q   <= burst_len;
                        pattern <= start_word;
                        count   <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        pattern <= next_pattern;
                        count   <= count + LEN_W'(1);
                    end
                    if (stop || last_word) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wr_fifo_pattern_gen.sv
// tb_wr_fifo_pattern_gen
//
// Directed bench for wr_fifo_pattern_gen at its default parameters. Each burst
// is started, the accepted words are compared against hand-computed sequences,
// and the end-of-burst status is checked. Inputs change 1 ns after the rising
// edge, and outputs are sampled 1 ns later.

module tb_wr_fifo_pattern_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic [15:0] burst_len;
    logic        full;
    logic        valid;
    logic [7:0]  dout;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;

    int checks;
    int failures;

    logic [7:0] expWords [0:15];

    wr_fifo_pattern_gen #(
        .DATA_W   (8),
        .LEN_W    (16),
        .LFSR_POLY(8'hB8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .seed     (seed),
        .burst_len(burst_len),
        .full     (full),
        .valid    (valid),
        .dout     (dout),
        .busy     (busy),
        .done     (done),
        .word_cnt (word_cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every comparison goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle with the given burst settings. It returns in
    // the first RUN cycle, with start already released.
    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] s, input logic [15:0] len);
        start     = 1'b1;
        mode      = m;
        seed      = s;
        burst_len = len;
        nextCycle();
        start = 1'b0;
    endtask

    // Collect n accepted words and compare them with expWords.
    // fullMode: 0 never full, 1 full toggles starting high, 2 full held high
    // for 20 cycles once two words have gone out.
    // stopLast asserts stop in the cycle of the n-th accept.
    // glitch re-asserts start with different settings during RUN.
    task automatic collect(input int n, input int fullMode, input bit stopLast, input bit glitch);
        int k;
        int cyc;
        int holdLeft;
        bit held;
        k = 0;
        cyc = 0;
        holdLeft = 0;
        held = 1'b0;
        while (k < n && cyc < 200) begin
            case (fullMode)
                1: full = (cyc % 2 == 0);
                2: begin
                    if (k == 2 && !held) begin
                        holdLeft = 20;
                        held = 1'b1;
                    end
                    full = (holdLeft > 0);
                end
                default: full = 1'b0;
            endcase
            stop = stopLast && (k == n - 1) && !full;
            if (glitch && k == 1) begin
                start = 1'b1;
                mode = 2'd0;
                seed = 8'h77;
                burst_len = 16'd9;
            end else begin
                start = 1'b0;
            end
            #1;
            if (valid) begin
                checkOutput($sformatf("word%0d", k), {24'h0, dout}, {24'h0, expWords[k]});
                k++;
            end else begin
                checkOutput("stall_dout", {24'h0, dout}, {24'h0, expWords[k]});
                checkOutput("stall_cnt", {16'h0, word_cnt}, k);
                checkOutput("stall_busy", {31'h0, busy}, 32'd1);
            end
            if (holdLeft > 0) holdLeft--;
            cyc++;
            nextCycle();
        end
        if (k < n) checkOutput("burst_timeout", k, n);
        full  = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("end_done", {31'h0, done}, 32'd1);
        checkOutput("end_busy", {31'h0, busy}, 32'd0);
        checkOutput("end_valid", {31'h0, valid}, 32'd0);
        checkOutput("end_cnt", {16'h0, word_cnt}, n);
        nextCycle();
        checkOutput("idle_done", {31'h0, done}, 32'd0);
        checkOutput("idle_busy", {31'h0, busy}, 32'd0);
        checkOutput("idle_valid", {31'h0, valid}, 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        mode = 2'd0;
        seed = 8'h00;
        burst_len = 16'd0;
        full = 1'b0;
        nextCycle();
        nextCycle();
        rst = 1'b0;
        checkOutput("rst_dout", {24'h0, dout}, 32'h0);
        checkOutput("rst_valid", {31'h0, valid}, 32'd0);
        checkOutput("rst_busy", {31'h0, busy}, 32'd0);
        checkOutput("rst_done", {31'h0, done}, 32'd0);
        checkOutput("rst_cnt", {16'h0, word_cnt}, 32'd0);
        nextCycle();

        // Alternating pattern, FIFO never full.
        $display("[TB] alternating burst");
        expWords[0] = 8'hAA; expWords[1] = 8'h55; expWords[2] = 8'hAA; expWords[3] = 8'h55;
        applyStimulus(2'd0, 8'hAA, 16'd4);
        checkOutput("start_busy", {31'h0, busy}, 32'd1);
        checkOutput("start_dout", {24'h0, dout}, 32'hAA);
        collect(4, 0, 1'b0, 1'b0);

        // Incrementing pattern across the wrap, full toggling every cycle.
        $display("[TB] increment burst with toggling full");
        expWords[0] = 8'hFE; expWords[1] = 8'hFF; expWords[2] = 8'h00; expWords[3] = 8'h01;
        applyStimulus(2'd1, 8'hFE, 16'd4);
        collect(4, 1, 1'b0, 1'b0);

        // LFSR pattern, then a zero seed that must start at 1.
        $display("[TB] lfsr bursts");
        expWords[0] = 8'h01; expWords[1] = 8'hB8; expWords[2] = 8'h5C; expWords[3] = 8'h2E;
        applyStimulus(2'd2, 8'h01, 16'd4);
        collect(4, 0, 1'b0, 1'b0);
        applyStimulus(2'd2, 8'h00, 16'd2);
        collect(2, 0, 1'b0, 1'b0);

        // Constant pattern in continuous mode, stopped with the 10th accept.
        $display("[TB] constant continuous burst with stop");
        for (int i = 0; i < 10; i++) expWords[i] = 8'h3C;
        applyStimulus(2'd3, 8'h3C, 16'd0);
        collect(10, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("post_stop_valid", {31'h0, valid}, 32'd0);
            checkOutput("post_stop_done", {31'h0, done}, 32'd0);
            nextCycle();
        end

        // A start during RUN must not disturb the latched settings.
        $display("[TB] start ignored during run");
        expWords[0] = 8'h10; expWords[1] = 8'h11; expWords[2] = 8'h12;
        applyStimulus(2'd1, 8'h10, 16'd3);
        collect(3, 0, 1'b0, 1'b1);

        // A long full stall in the middle of a burst.
        $display("[TB] long full stall");
        expWords[0] = 8'h0F; expWords[1] = 8'hF0; expWords[2] = 8'h0F;
        expWords[3] = 8'hF0; expWords[4] = 8'h0F;
        applyStimulus(2'd0, 8'h0F, 16'd5);
        collect(5, 2, 1'b0, 1'b0);

        // Reset in the middle of a burst.
        $display("[TB] reset mid-burst");
        applyStimulus(2'd1, 8'h05, 16'd8);
        nextCycle();
        nextCycle();
        checkOutput("pre_rst_cnt", {16'h0, word_cnt}, 32'd2);
        checkOutput("pre_rst_dout", {24'h0, dout}, 32'h07);
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        checkOutput("mid_rst_dout", {24'h0, dout}, 32'h0);
        checkOutput("mid_rst_valid", {31'h0, valid}, 32'd0);
        checkOutput("mid_rst_busy", {31'h0, busy}, 32'd0);
        checkOutput("mid_rst_done", {31'h0, done}, 32'd0);
        checkOutput("mid_rst_cnt", {16'h0, word_cnt}, 32'd0);
        nextCycle();
        checkOutput("after_rst_done", {31'h0, done}, 32'd0);
        checkOutput("after_rst_busy", {31'h0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
